// File: rtl/uart_pkg.sv
// Shared types and helpers for the debug UART receive path.
// FSM encoding and oversample sample-point helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    S_BREAK,
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_e;

  // Majority-vote sample indices around the bit centre.
  function automatic int samp_lo(input int os);
    return os / 2 - 1;
  endfunction

  function automatic int samp_mid(input int os);
    return os / 2;
  endfunction

  function automatic int samp_hi(input int os);
    return os / 2 + 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick divider for the UART receiver.
// Counts BAUD_DIV down to zero; restart re-phases to a start edge.
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 FIFO_WR_CLK,
  input  logic                 RST_N,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 restart,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (restart || cnt_q == '0) begin
      cnt_d = div;
    end
    tick = (cnt_q == '0) && !restart;
  end

  always_ff @(posedge FIFO_WR_CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_wr.sv
// Debug UART receiver: oversampled RXD deserialiser that
// pushes each good byte into the dual-clock FIFO write port.
module uart_rx_fifo_wr
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  RST_N,
  input  logic                  FIFO_WR_CLK,
  input  logic                  RXD,
  input  logic [DIV_WIDTH-1:0]  BAUD_DIV,
  input  logic                  PARITY_EN,
  input  logic                  PARITY_ODD,
  input  logic                  ERR_CLR,
  output logic                  FIFO_WR_ENA,
  output logic [DATA_WIDTH-1:0] FIFO_WR_DATA,
  output logic                  FIFO_WR_LAST,
  input  logic                  FIFO_WR_FULL,
  output logic                  FRAME_ERR,
  output logic                  PARITY_ERR,
  output logic                  OVERRUN,
  output logic                  BUSY
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TW-1:0] T_LO  = TW'(samp_lo(OVERSAMPLE));
  localparam logic [TW-1:0] T_MID = TW'(samp_mid(OVERSAMPLE));
  localparam logic [TW-1:0] T_HI  = TW'(samp_hi(OVERSAMPLE));
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_END = BW'(DATA_WIDTH - 1);

  uart_state_e state_q, state_d;

  logic [1:0]            sync_q;
  logic                  rxp_q;
  logic                  rx;
  logic                  fall;

  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic [1:0]            smp_q, smp_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  pen_q, pen_d;
  logic                  podd_q, podd_d;
  logic                  pbad_q, pbad_d;
  logic                  fe_q, fe_d;
  logic                  pe_q, pe_d;
  logic                  ov_q, ov_d;
  logic                  wr_ena_q, wr_ena_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic tick;
  logic restart;
  logic push;
  logic set_fe, set_pe, set_ov;
  logic at_lo, at_mid, at_hi, at_end;
  logic maj;

  uart_baud_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud (
    .FIFO_WR_CLK (FIFO_WR_CLK),
    .RST_N       (RST_N),
    .div         (BAUD_DIV),
    .restart     (restart),
    .tick        (tick)
  );

  assign rx   = sync_q[1];
  assign fall = rxp_q & ~rx;

  assign at_lo  = tick && (tcnt_q == T_LO);
  assign at_mid = tick && (tcnt_q == T_MID);
  assign at_hi  = tick && (tcnt_q == T_HI);
  assign at_end = tick && (tcnt_q == T_END);

  // Third sample is taken live at the T_HI tick.
  assign maj = (smp_q[0] & smp_q[1]) |
               (smp_q[0] & rx) |
               (smp_q[1] & rx);

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    smp_d   = smp_q;
    shreg_d = shreg_q;
    pen_d   = pen_q;
    podd_d  = podd_q;
    pbad_d  = pbad_q;
    restart = 1'b0;
    push    = 1'b0;
    set_fe  = 1'b0;
    set_pe  = 1'b0;
    set_ov  = 1'b0;

    if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP}) begin
      if (tick) begin
        tcnt_d = at_end ? '0 : tcnt_q + TW'(1);
      end
      if (at_lo) begin
        smp_d[0] = rx;
      end
      if (at_mid) begin
        smp_d[1] = rx;
      end
    end

    unique case (state_q)
      S_BREAK: begin
        if (!rx) begin
          tcnt_d = '0;
        end else if (tick) begin
          if (tcnt_q == T_END) begin
            tcnt_d  = '0;
            state_d = S_IDLE;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      S_IDLE: begin
        tcnt_d = '0;
        bcnt_d = '0;
        if (fall) begin
          restart = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (at_hi) begin
          if (maj) begin
            state_d = S_IDLE;
          end else begin
            pen_d  = PARITY_EN;
            podd_d = PARITY_ODD;
            pbad_d = 1'b0;
          end
        end else if (at_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (at_hi) begin
          shreg_d = {maj, shreg_q[DATA_WIDTH-1:1]};
        end else if (at_end) begin
          bcnt_d = bcnt_q + BW'(1);
          if (bcnt_q == B_END) begin
            bcnt_d  = '0;
            state_d = pen_q ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (at_hi) begin
          pbad_d = maj ^ (^shreg_q) ^ podd_q;
        end else if (at_end) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (at_hi) begin
          state_d = S_IDLE;
          if (!maj) begin
            set_fe  = 1'b1;
            tcnt_d  = '0;
            state_d = S_BREAK;
          end else if (pbad_q) begin
            set_pe = 1'b1;
          end else if (FIFO_WR_FULL) begin
            set_ov = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_BREAK;
      end
    endcase
  end

  // Sticky flags: a new error in the clear cycle wins.
  always_comb begin
    fe_d      = (fe_q & ~ERR_CLR) | set_fe;
    pe_d      = (pe_q & ~ERR_CLR) | set_pe;
    ov_d      = (ov_q & ~ERR_CLR) | set_ov;
    wr_ena_d  = push;
    wr_data_d = push ? shreg_q : wr_data_q;
  end

  always_ff @(posedge FIFO_WR_CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q    <= 2'b11;
      rxp_q     <= 1'b1;
      state_q   <= S_BREAK;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      smp_q     <= '0;
      shreg_q   <= '0;
      pen_q     <= 1'b0;
      podd_q    <= 1'b0;
      pbad_q    <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      ov_q      <= 1'b0;
      wr_ena_q  <= 1'b0;
      wr_data_q <= '0;
    end else begin
      sync_q    <= {sync_q[0], RXD};
      rxp_q     <= sync_q[1];
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      smp_q     <= smp_d;
      shreg_q   <= shreg_d;
      pen_q     <= pen_d;
      podd_q    <= podd_d;
      pbad_q    <= pbad_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
      ov_q      <= ov_d;
      wr_ena_q  <= wr_ena_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign FIFO_WR_ENA  = wr_ena_q;
  assign FIFO_WR_LAST = wr_ena_q;
  assign FIFO_WR_DATA = wr_data_q;
  assign FRAME_ERR    = fe_q;
  assign PARITY_ERR   = pe_q;
  assign OVERRUN      = ov_q;
  assign BUSY         = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_fifo_wr.md
Name: uart_rx_fifo_wr

Overview:
Serial receive front end of the debug UART. It oversamples the asynchronous RXD line, deserialises 8-bit frames (LSB first, optional parity, one stop bit) and pushes each good byte into the write port of the dual-clock FIFO. The block runs entirely in the FIFO write clock domain. Every push carries FIFO_WR_LAST so the FIFO publishes its write pointer to the read side byte by byte.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- DIV_WIDTH, 16, width of the BAUD_DIV input.
- OVERSAMPLE, 16, oversample ticks per bit; must be even and at least 8.

Ports:
- RST_N  in  1  asynchronous reset, active low.
- FIFO_WR_CLK  in  1  block clock; also the FIFO write clock.
- RXD  in  1  asynchronous serial input; idles high.
- BAUD_DIV  in  DIV_WIDTH  one oversample tick every BAUD_DIV+1 clocks; sampled continuously.
- PARITY_EN  in  1  1 = frame contains a parity bit.
- PARITY_ODD  in  1  1 = odd parity, 0 = even parity.
- ERR_CLR  in  1  single-cycle clear of the sticky error flags.
- FIFO_WR_ENA  out  1  single-cycle push strobe.
- FIFO_WR_DATA  out  DATA_WIDTH  received byte; valid while FIFO_WR_ENA is high.
- FIFO_WR_LAST  out  1  equals FIFO_WR_ENA.
- FIFO_WR_FULL  in  1  FIFO full flag.
- FRAME_ERR  out  1  sticky: stop bit sampled low.
- PARITY_ERR  out  1  sticky: parity mismatch.
- OVERRUN  out  1  sticky: byte dropped because the FIFO was full.
- BUSY  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: RST_N is asynchronous and active low; the clock is FIFO_WR_CLK. All outputs go to 0 except BUSY, which is 1 because the FSM resets into BREAK. The synchroniser flops reset to 1. Tick and bit counters and the shift register reset to 0.
- Synchroniser: 2-FF on RXD; all logic uses the synchronised value. Input-to-FSM latency is 2 clocks.
- Tick generator:
  - The divider counter counts down from BAUD_DIV to 0. Tick = counter at 0, after which it reloads.
  - BAUD_DIV=0 gives a tick on every clock.
  - The divider is restarted (phase aligned) on start-edge detection.
- Sample point: the majority of 3 samples at tick indices OVERSAMPLE/2-1, /2 and /2+1 within the bit (7, 8, 9 for 16x). A bit period is OVERSAMPLE ticks.
- FSM states:
  - BREAK: wait until the synchronised RXD has been high for OVERSAMPLE consecutive ticks, then go to IDLE. Entered at reset and after a frame error, so a held-low line never produces data.
  - IDLE: on a 1-to-0 transition go to START and clear the tick and bit counters.
  - START: if the mid-bit majority is 1, the start is false; go to IDLE with no flags set. Otherwise continue counting to the end of the bit, then go to DATA.
  - DATA: shift in DATA_WIDTH bits LSB first, one per bit period. Go to PARITY if PARITY_EN, else STOP.
  - PARITY: compute expected = XOR(data) XOR PARITY_ODD; a mismatch marks the byte bad.
  - STOP: evaluated at the stop-bit mid-sample, then return without waiting for the bit end so that back-to-back frames resync early.
    - Majority 0: set FRAME_ERR, drop the byte, go to BREAK.
    - Majority 1 with a parity mismatch: set PARITY_ERR, drop the byte, go to IDLE.
    - Majority 1 with good parity and FIFO_WR_FULL=1: set OVERRUN, drop the byte, go to IDLE.
    - Majority 1 with good parity and FIFO_WR_FULL=0: assert FIFO_WR_ENA and FIFO_WR_LAST for exactly 1 clock, on the clock after the third stop sample; then go to IDLE.
- FIFO_WR_FULL is sampled in the same cycle the push decision is made; there are no retries.
- Flags: sticky until ERR_CLR. If ERR_CLR coincides with a new error, the set wins.
- PARITY_EN and PARITY_ODD are sampled at start-bit validation and held for the rest of the frame. Changing them mid-frame has no effect on the current frame.
- Reset asserted mid-frame aborts the frame with no write. Flags clear, and the FSM resumes in BREAK.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (BREAK, IDLE, START, DATA, PARITY, STOP);
  - the sample-index constants derived from OVERSAMPLE.
- One sub-module, uart_baud_gen: the divider counter, the restart input and the tick output.

Test Plan:
- BAUD_DIV=3 (tick every 4 clocks, bit = 64 clocks), 8N1, send 0xA5 after 64+ idle clocks -> exactly one FIFO_WR_ENA pulse with DATA=0xA5 and LAST=1; no flags set.
- RXD low for 16 clocks (glitch shorter than half a bit), then high -> no write, no flags, FSM back in IDLE.
- Send 0x3C with the stop bit driven 0 -> no write, FRAME_ERR=1. Then pulse ERR_CLR -> flag clears. The next 0x3C is received only after RXD has been high for 64 clocks.
- PARITY_EN=1, PARITY_ODD=0: send 0x01 with parity bit 1 -> write of 0x01. Send 0x01 with parity bit 0 -> no write, PARITY_ERR=1.
- Hold FIFO_WR_FULL=1 while 0x55 completes -> no FIFO_WR_ENA, OVERRUN=1. Release FULL and send 0x66 -> write of 0x66 while OVERRUN stays 1.
- Back-to-back 0x00, 0xFF, 0x81 with no idle gap -> three writes spaced 640 clocks apart, data in order. Assert RST_N low mid-way through a fourth frame -> no fourth write, all outputs at reset values.
